led_breathe: RTL and testbench

PWM "breathing" LED driver, the stage directly downstream of the board's oscillator-driven clock divider. It consumes the divider's single-cycle step strobe. On each strobe it ramps a duty-cycle level up, holds, ramps down and holds, in a repeating loop. It produces a PWM LED drive from a free-running counter on the fabric clock. It replaces the fixed 50% square-wave LED toggle with a smooth brightness envelope.

---
 rtl/led_breathe_if.sv | 30 +++
 rtl/led_breathe.sv | 118 +++++++++++
 tb/tb_led_breathe.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/led_breathe_if.sv
// Step-strobe / LED status bundle between the divider side
// and the breathing LED driver.
interface led_breathe_if #(
  parameter int PWM_BITS = 8
);
  logic                en;
  logic                tick;
  logic                led;
  logic [PWM_BITS-1:0] level;
  logic [2:0]          phase;
  logic                cycle_done;

  modport master (
    output en,
    output tick,
    input  led,
    input  level,
    input  phase,
    input  cycle_done
  );

  modport slave (
    input  en,
    input  tick,
    output led,
    output level,
    output phase,
    output cycle_done
  );
endinterface

// File: rtl/led_breathe.sv
// PWM breathing LED: tick-stepped duty envelope
// (rise, hold, fall, hold) compared against a free-running counter.
module led_breathe #(
  parameter int PWM_BITS   = 8,
  parameter int HOLD_TICKS = 4
) (
  input logic         clk,
  input logic         rst_n,
  led_breathe_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  localparam int HW =
    (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(HOLD_TICKS - 1);

  state_t              state, state_n;
  logic [PWM_BITS-1:0] level, level_n;
  logic [PWM_BITS-1:0] level_inc, level_dec;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [HW-1:0]       hold, hold_n;
  logic                done, done_n;
  logic                led;

  assign level_inc = level + 1'b1;
  assign level_dec = level - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      level   <= '0;
      hold    <= '0;
      done    <= 1'b0;
      led     <= 1'b0;
      pwm_cnt <= '0;
    end else begin
      state   <= state_n;
      level   <= level_n;
      hold    <= hold_n;
      done    <= done_n;
      pwm_cnt <= pwm_cnt + 1'b1;
      led     <= bus.en && (state != IDLE) &&
                 (pwm_cnt < level);
    end
  end

  // Dropping en overrides every state, so ticks are lost that cycle
  always_comb begin
    state_n = state;
    level_n = level;
    hold_n  = hold;
    done_n  = 1'b0;
    if (!bus.en) begin
      state_n = IDLE;
      level_n = '0;
      hold_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = RISE;
          level_n = '0;
          hold_n  = '0;
        end
        RISE: if (bus.tick) begin
          level_n = level_inc;
          if (level_inc == MAX) begin
            state_n = HOLD_HI;
            hold_n  = '0;
          end
        end
        HOLD_HI: if (bus.tick) begin
          if (hold == HOLD_LAST) begin
            state_n = FALL;
            hold_n  = '0;
          end else begin
            hold_n = hold + 1'b1;
          end
        end
        FALL: if (bus.tick) begin
          level_n = level_dec;
          if (level_dec == '0) begin
            state_n = HOLD_LO;
            hold_n  = '0;
          end
        end
        HOLD_LO: if (bus.tick) begin
          if (hold == HOLD_LAST) begin
            state_n = RISE;
            hold_n  = '0;
            done_n  = 1'b1;
          end else begin
            hold_n = hold + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          level_n = '0;
          hold_n  = '0;
        end
      endcase
    end
  end

  assign bus.led        = led;
  assign bus.level      = level;
  assign bus.phase      = state;
  assign bus.cycle_done = done;

endmodule

// File: tb/tb_led_breathe.sv
// Directed bench for led_breathe at PWM_BITS=3,
// HOLD_TICKS=2 (MAX=7, breath = 18 ticks).
module tb_led_breathe;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   c;

  led_breathe_if #(.PWM_BITS(3)) bus ();

  led_breathe #(
    .PWM_BITS  (3),
    .HOLD_TICKS(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic count_led(output int cnt);
    cnt = 0;
    repeat (8) begin
      cnt += int'(bus.led);
      step();
    end
  endtask

  int exp_lvl[18] = '{1, 2, 3, 4, 5, 6, 7, 7, 7,
                      6, 5, 4, 3, 2, 1, 0, 0, 0};
  int exp_ph[18]  = '{1, 1, 1, 1, 1, 1, 2, 2, 3,
                      3, 3, 3, 3, 3, 3, 4, 4, 1};

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.en   = 1'b1;
    bus.tick = 1'b0;

    // 1: reset held with en and ticks active
    for (int i = 0; i < 20; i++) begin
      bus.tick = i[0];
      step();
      chk("reset_outs",
          32'({bus.led, bus.level, bus.phase,
               bus.cycle_done}), 0);
    end
    bus.tick = 1'b0;
    rst_n    = 1'b1;
    step();
    chk("rel_phase", 32'(bus.phase), 1);
    chk("rel_level", 32'(bus.level), 0);

    // 2: two full breaths, tick every 4 cycles
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 18; k++) begin
        pulse();
        chk("br_level", 32'(bus.level), exp_lvl[k]);
        chk("br_phase", 32'(bus.phase), exp_ph[k]);
        chk("br_done", 32'(bus.cycle_done),
            (k == 17) ? 1 : 0);
        step();
        chk("br_done_off", 32'(bus.cycle_done), 0);
        step();
        step();
      end
    end

    // 3: duty at levels 3, 7, 0
    repeat (3) pulse();
    chk("d3_level", 32'(bus.level), 3);
    step();
    count_led(c);
    chk("duty3", 32'(c), 3);
    repeat (4) pulse();
    chk("d7_level", 32'(bus.level), 7);
    step();
    count_led(c);
    chk("duty7", 32'(c), 7);
    repeat (9) pulse();
    chk("d0_level", 32'(bus.level), 0);
    chk("d0_phase", 32'(bus.phase), 4);
    step();
    count_led(c);
    chk("duty0", 32'(c), 0);

    // 4: disable in FALL at level 4
    repeat (2) pulse();
    chk("d4_rise", 32'(bus.phase), 1);
    repeat (9) pulse();
    repeat (3) pulse();
    chk("fall_level", 32'(bus.level), 4);
    chk("fall_phase", 32'(bus.phase), 3);
    bus.en   = 1'b0;
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    chk("dis_phase", 32'(bus.phase), 0);
    chk("dis_level", 32'(bus.level), 0);
    chk("dis_led", 32'(bus.led), 0);
    bus.en = 1'b1;
    step();
    chk("reen_phase", 32'(bus.phase), 1);
    chk("reen_level", 32'(bus.level), 0);
    pulse();
    chk("reen_tick", 32'(bus.level), 1);

    // 5: tick coincident with en rising
    bus.en = 1'b0;
    step();
    bus.en   = 1'b1;
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    chk("coin_phase", 32'(bus.phase), 1);
    chk("coin_level", 32'(bus.level), 0);
    step();
    step();
    chk("coin_hold", 32'(bus.level), 0);
    pulse();
    chk("coin_next", 32'(bus.level), 1);

    // 6: async reset between edges in HOLD_HI
    repeat (6) pulse();
    chk("hh_phase", 32'(bus.phase), 2);
    chk("hh_level", 32'(bus.level), 7);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_outs",
        32'({bus.led, bus.level, bus.phase,
             bus.cycle_done}), 0);
    step();
    chk("arst_hold", 32'(bus.phase), 0);
    rst_n = 1'b1;
    step();
    chk("arst_rel", 32'(bus.phase), 1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
